wbuf_send_seq: RTL and testbench
================================

Name: wbuf_send_seq

Overview:
- Parametrised weight-buffer read sequencer. It is the successor to the fixed 8-beat wbuf_send.
- A single start pulse makes it issue `loop` passes of BEATS reads to the weight SRAM. Reads are driven through RCEBX (active-low) and RADDR. Each returned beat is qualified with WBUF_EN one cycle later.
- New behaviour:
  - destination back-pressure (RDY)
  - linear or repeat addressing mode
  - BUSY/DONE status
  - parametrised widths and beat count

Parameters:
- LOOP_W, 8, width of loop and COUNTER0.
- BEATS, 8, reads per loop pass (≥2).
- BEAT_W, 3, width of cnt; must satisfy 2**BEAT_W ≥ BEATS.
- ADDR_W, 10, SRAM address width.

Ports:
- CLK  in  1  clock, rising edge.
- RSTL  in  1  asynchronous active-low reset.
- WBUF_SEND  in  1  start pulse; sampled only in IDLE.
- loop  in  LOOP_W  number of passes; latched at start.
- MODE  in  1  0 = linear, 1 = repeat; latched at start.
- BASE_ADDR  in  ADDR_W  first read address; latched at start.
- RDY  in  1  destination can take a new read this cycle.
- cnt  out  BEAT_W  beat index within the current pass.
- COUNTER0  out  LOOP_W  index of the current pass.
- RADDR  out  ADDR_W  SRAM read address.
- RCEBX  out  1  SRAM read chip enable, active-low.
- WBUF_EN  out  1  read data valid (1-cycle SRAM latency).
- BUSY  out  1  high in RUN and DRAIN.
- DONE  out  1  single-cycle completion pulse.

Behaviour:
- Reset (async, RSTL=0):
  - state=IDLE.
  - cnt=0, COUNTER0=0, RADDR=0, WBUF_EN=0, BUSY=0, DONE=0, RCEBX=1.
  - All latched config is cleared.
  - Reset mid-operation abandons the transfer. No DONE is produced.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - On WBUF_SEND=1 with loop≠0: latch loop, MODE and BASE_ADDR; cnt←0, COUNTER0←0, addr←BASE_ADDR; go to RUN.
  - On WBUF_SEND=1 with loop=0: DONE=1 for the next cycle only; stay IDLE; no reads are issued.
- Issue:
  - issue = (state==RUN) & RDY.
  - RCEBX = ~issue. This is combinational from registered state and RDY.
  - RADDR = the addr register (always driven; meaningful only while issue=1).
- Counter update on each issue:
  - cnt increments. At BEATS-1 it wraps to 0 and COUNTER0 increments.
  - Linear mode: addr increments every issue, modulo 2**ADDR_W, so it wraps silently.
  - Repeat mode: addr increments within a pass and reloads BASE_ADDR at each pass boundary. Every pass re-reads the same BEATS words.
- Last issue: cnt==BEATS-1 and COUNTER0==loop_q-1 → go to DRAIN. cnt and COUNTER0 return to 0.
- WBUF_EN: registered copy of issue, so it is high exactly one cycle after each RCEBX-low cycle.
- Back-pressure:
  - RDY=0 in RUN holds all counters and addr and keeps RCEBX=1.
  - A beat already issued still produces WBUF_EN the following cycle, even if RDY is low then. The destination must absorb this one in-flight beat.
- DRAIN: lasts exactly one cycle. WBUF_EN=1 for the final beat, DONE=1, BUSY=1. Next state is IDLE.
- WBUF_SEND in RUN or DRAIN is ignored. It is not queued.
- Total issue cycles = loop × BEATS. With RDY held high, WBUF_SEND→DONE latency is loop × BEATS + 1 cycles after the start edge.

Decomposition:
- A shared package (wbuf_pkg) holds:
  - the state encoding localparams (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2)
  - the MODE constants (MODE_LINEAR=0, MODE_REPEAT=1)
- Sub-module wbuf_addr_gen holds the cnt/COUNTER0/addr counters, with inputs load, step and mode, and outputs wrap and last.
- The top level holds the FSM, the issue logic and the WBUF_EN/DONE registers.

Test Plan:
- Linear, loop=5, BASE=0, RDY=1, WBUF_SEND 1-cycle pulse after reset →
  - 40 consecutive RCEBX-low cycles with RADDR 0..39
  - WBUF_EN high for cycles 2..41 after start
  - DONE=1 in cycle 41, then BUSY=0
- Repeat, loop=3, BASE=100 → RADDR sequence 100..107 three times; COUNTER0 steps 0→1→2; 24 WBUF_EN pulses; one DONE.
- RDY toggled 1,0,0,1… during linear loop=2 →
  - no RCEBX-low cycle while RDY=0
  - exactly one trailing WBUF_EN after each RDY fall
  - address sequence unbroken; 16 total beats
- Linear, BASE=1020, ADDR_W=10, loop=1 → RADDR 1020..1023, then 0..3; DONE after 8 beats.
- loop=0 start → no RCEBX activity; DONE=1 one cycle; BUSY stays 0.
- RSTL pulled low at beat 10 of loop=5 → all outputs return to reset values immediately. No DONE. A new WBUF_SEND after reset starts again from BASE_ADDR.

Source files
------------

// File: rtl/wbuf_pkg.sv
`default_nettype none
// ============================================================================
// Module  : wbuf_pkg
// Brief   : Shared state and addressing-mode encodings for the weight-buffer
//           read sequencer.
// Revision: 1.0
// ============================================================================
package wbuf_pkg;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = c_ST_IDLE,
        RUN   = c_ST_RUN,
        DRAIN = c_ST_DRAIN
    } state_t;

    localparam logic MODE_LINEAR = 1'b0;
    localparam logic MODE_REPEAT = 1'b1;

endpackage
`default_nettype wire

// File: rtl/wbuf_addr_gen.sv
`default_nettype none
// ============================================================================
// Module  : wbuf_addr_gen
// Brief   : Beat / pass / address counters with start-time config latching.
// Revision: 1.0
// ============================================================================
module wbuf_addr_gen
    import wbuf_pkg::*;
#(
    parameter int LOOP_W = 8,
    parameter int BEATS  = 8,
    parameter int BEAT_W = 3,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic              mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LOOP_W-1:0] loop,
    output logic [BEAT_W-1:0] cnt,
    output logic [LOOP_W-1:0] counter0,
    output logic [ADDR_W-1:0] addr,
    output logic              wrap,
    output logic              last
);

    localparam logic [BEAT_W-1:0] c_LAST_BEAT = BEAT_W'(BEATS - 1);

    logic [BEAT_W-1:0] r_cnt;
    logic [LOOP_W-1:0] r_pass;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_base;
    logic [LOOP_W-1:0] r_loop;
    logic              r_mode;

    assign cnt      = r_cnt;
    assign counter0 = r_pass;
    assign addr     = r_addr;
    assign wrap     = (r_cnt == c_LAST_BEAT);
    // "last" flags the final pass; the final beat is wrap && last.
    assign last     = (r_pass == (r_loop - LOOP_W'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_pass <= '0;
            r_addr <= '0;
            r_base <= '0;
            r_loop <= '0;
            r_mode <= MODE_LINEAR;
        end else if (load) begin
            r_mode <= mode;
            r_base <= base_addr;
            r_loop <= loop;
            r_cnt  <= '0;
            r_pass <= '0;
            r_addr <= base_addr;
        end else if (step) begin
            if (wrap) begin
                r_cnt  <= '0;
                r_pass <= last ? '0 : r_pass + LOOP_W'(1);
                r_addr <= (r_mode == MODE_REPEAT) ? r_base : r_addr + ADDR_W'(1);
            end else begin
                r_cnt  <= r_cnt + BEAT_W'(1);
                r_addr <= r_addr + ADDR_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/wbuf_send_seq.sv
`default_nettype none
// ============================================================================
// Module  : wbuf_send_seq
// Brief   : Weight-buffer read sequencer: loop x BEATS SRAM reads per start,
//           with back-pressure, linear/repeat addressing and BUSY/DONE status.
// Revision: 1.0
// ============================================================================
module wbuf_send_seq
    import wbuf_pkg::*;
#(
    parameter int LOOP_W = 8,
    parameter int BEATS  = 8,
    parameter int BEAT_W = 3,
    parameter int ADDR_W = 10
) (
    input  logic              CLK,
    input  logic              RSTL,
    input  logic              WBUF_SEND,
    input  logic [LOOP_W-1:0] loop,
    input  logic              MODE,
    input  logic [ADDR_W-1:0] BASE_ADDR,
    input  logic              RDY,
    output logic [BEAT_W-1:0] cnt,
    output logic [LOOP_W-1:0] COUNTER0,
    output logic [ADDR_W-1:0] RADDR,
    output logic              RCEBX,
    output logic              WBUF_EN,
    output logic              BUSY,
    output logic              DONE
);

    state_t r_state;
    state_t w_next;
    logic   w_issue;
    logic   w_start;
    logic   w_load;
    logic   w_zero_start;
    logic   w_final;
    logic   w_wrap;
    logic   w_last;
    logic   r_wbuf_en;
    logic   r_done;

    wbuf_addr_gen #(
        .LOOP_W (LOOP_W),
        .BEATS  (BEATS),
        .BEAT_W (BEAT_W),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk       (CLK),
        .rst_n     (RSTL),
        .load      (w_load),
        .step      (w_issue),
        .mode      (MODE),
        .base_addr (BASE_ADDR),
        .loop      (loop),
        .cnt       (cnt),
        .counter0  (COUNTER0),
        .addr      (RADDR),
        .wrap      (w_wrap),
        .last      (w_last)
    );

    always_ff @(posedge CLK or negedge RSTL) begin
        if (!RSTL) begin
            r_state   <= IDLE;
            r_wbuf_en <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_wbuf_en <= w_issue;
            // DONE lands in the DRAIN cycle, or one cycle after a loop=0 start.
            r_done    <= w_final | w_zero_start;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_issue      = 1'b0;
        w_start      = 1'b0;
        w_load       = 1'b0;
        w_zero_start = 1'b0;
        w_final      = 1'b0;
        case (r_state)
            IDLE: begin
                w_start      = WBUF_SEND;
                w_load       = WBUF_SEND && (loop != '0);
                w_zero_start = WBUF_SEND && (loop == '0);
                if (w_load) w_next = RUN;
            end
            RUN: begin
                w_issue = RDY;
                w_final = RDY && w_wrap && w_last;
                if (w_final) w_next = DRAIN;
            end
            DRAIN:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign RCEBX   = ~w_issue;
    assign WBUF_EN = r_wbuf_en;
    assign DONE    = r_done;
    assign BUSY    = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_wbuf_send_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_wbuf_send_seq
// Brief   : Directed self-checking bench for wbuf_send_seq.
// Revision: 1.0
// ============================================================================
module tb_wbuf_send_seq;

    logic       CLK = 1'b0;
    logic       RSTL;
    logic       WBUF_SEND;
    logic [7:0] loop;
    logic       MODE;
    logic [9:0] BASE_ADDR;
    logic       RDY;
    logic [2:0] cnt;
    logic [7:0] COUNTER0;
    logic [9:0] RADDR;
    logic       RCEBX;
    logic       WBUF_EN;
    logic       BUSY;
    logic       DONE;

    int passes = 0;
    int total  = 0;

    always #5 CLK = ~CLK;

    wbuf_send_seq #(
        .LOOP_W (8),
        .BEATS  (8),
        .BEAT_W (3),
        .ADDR_W (10)
    ) dut (
        .CLK       (CLK),
        .RSTL      (RSTL),
        .WBUF_SEND (WBUF_SEND),
        .loop      (loop),
        .MODE      (MODE),
        .BASE_ADDR (BASE_ADDR),
        .RDY       (RDY),
        .cnt       (cnt),
        .COUNTER0  (COUNTER0),
        .RADDR     (RADDR),
        .RCEBX     (RCEBX),
        .WBUF_EN   (WBUF_EN),
        .BUSY      (BUSY),
        .DONE      (DONE)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " cnt"},      32'(cnt),      0);
        chk({tag, " COUNTER0"}, 32'(COUNTER0), 0);
        chk({tag, " WBUF_EN"},  32'(WBUF_EN),  0);
        chk({tag, " BUSY"},     32'(BUSY),     0);
        chk({tag, " DONE"},     32'(DONE),     0);
        chk({tag, " RCEBX"},    32'(RCEBX),    1);
    endtask

    // kind 0: RDY always 1; kind 1: RDY pattern 1,0,0,1 repeating.
    function automatic logic rdy_at(input int kind, input int cyc);
        if (kind == 0) return 1'b1;
        return (cyc % 4 == 0) || (cyc % 4 == 3);
    endfunction

    function automatic int exp_addr(input bit md, input int base, input int k);
        if (md) return base + (k % 8);
        return (base + k) % 1024;
    endfunction

    // One full transfer; poke_send keeps WBUF_SEND high during RUN to show it is ignored.
    task automatic run_xfer(input string tag, input int lp, input bit md, input int base,
                            input int kind, input bit poke_send);
        int k    = 0;
        int cyc  = 0;
        int nen  = 0;
        logic prev = 1'b0;
        @(posedge CLK); #1;
        WBUF_SEND = 1'b1; loop = 8'(lp); MODE = md; BASE_ADDR = 10'(base);
        @(posedge CLK); #1;
        WBUF_SEND = poke_send;
        loop = 8'hA5; MODE = ~md; BASE_ADDR = 10'h155;
        while (k < lp * 8) begin
            RDY = rdy_at(kind, cyc);
            #1;
            chk({tag, " BUSY"},     32'(BUSY),     1);
            chk({tag, " DONE"},     32'(DONE),     0);
            chk({tag, " RCEBX"},    32'(RCEBX),    32'(!RDY));
            chk({tag, " WBUF_EN"},  32'(WBUF_EN),  32'(prev));
            chk({tag, " RADDR"},    32'(RADDR),    32'(exp_addr(md, base, k)));
            chk({tag, " cnt"},      32'(cnt),      32'(k % 8));
            chk({tag, " COUNTER0"}, 32'(COUNTER0), 32'(k / 8));
            nen += int'(WBUF_EN);
            if (RDY) k++;
            prev = RDY;
            cyc++;
            if (cyc > 4 * lp * 8 + 8) begin
                chk({tag, " timeout"}, 32'(k), 32'(lp * 8));
                break;
            end
            @(posedge CLK); #1;
        end
        WBUF_SEND = 1'b0; RDY = 1'b1;
        #1;
        chk({tag, " drain WBUF_EN"}, 32'(WBUF_EN), 1);
        chk({tag, " drain DONE"},    32'(DONE),    1);
        chk({tag, " drain BUSY"},    32'(BUSY),    1);
        chk({tag, " drain RCEBX"},   32'(RCEBX),   1);
        nen += int'(WBUF_EN);
        chk({tag, " beats"}, 32'(nen), 32'(lp * 8));
        @(posedge CLK); #2;
        chk_idle({tag, " after"});
    endtask

    initial begin
        RSTL = 1'b0; WBUF_SEND = 1'b0; loop = '0; MODE = 1'b0; BASE_ADDR = '0; RDY = 1'b1;
        repeat (2) @(posedge CLK);
        #2;
        chk_idle("reset");
        chk("reset RADDR", 32'(RADDR), 0);
        RSTL = 1'b1;

        run_xfer("lin5",   5, 1'b0, 0,    0, 1'b1);
        run_xfer("rep3",   3, 1'b1, 100,  0, 1'b0);
        run_xfer("bp2",    2, 1'b0, 40,   1, 1'b0);
        run_xfer("wrap1",  1, 1'b0, 1020, 0, 1'b0);

        // loop=0: DONE only, no reads.
        @(posedge CLK); #1;
        WBUF_SEND = 1'b1; loop = 8'd0;
        @(posedge CLK); #1;
        WBUF_SEND = 1'b0; #1;
        chk("zero DONE",  32'(DONE),  1);
        chk("zero BUSY",  32'(BUSY),  0);
        chk("zero RCEBX", 32'(RCEBX), 1);
        @(posedge CLK); #2;
        chk_idle("zero after");

        // Reset after 10 beats of a loop=5 transfer.
        @(posedge CLK); #1;
        WBUF_SEND = 1'b1; loop = 8'd5; MODE = 1'b0; BASE_ADDR = 10'd0;
        @(posedge CLK); #1;
        WBUF_SEND = 1'b0;
        repeat (10) @(posedge CLK);
        #1;
        chk("pre-rst RADDR", 32'(RADDR), 10);
        RSTL = 1'b0; #1;
        chk_idle("midrst");
        chk("midrst RADDR", 32'(RADDR), 0);
        @(posedge CLK); #1;
        RSTL = 1'b1;
        @(posedge CLK); #2;
        chk_idle("postrst");
        run_xfer("restart", 1, 1'b0, 0, 0, 1'b0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
`default_nettype wire
